// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Each grant latches a byte, runs the send/done handshake, then acks or times out.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           err_id
);
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       LAST_IDX = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_s, ack_r, ack_s, win_oh_s;
    logic               tx_send_r, tx_send_s, busy_r, busy_s, err_r, err_s, found_s;
    logic [7:0]         tx_data_r, tx_data_s, win_data_s;
    logic [2:0]         err_id_r, err_id_s, ptr_r, ptr_s, idx_r, idx_s, win_s, next_ptr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;

    // Returns {found, index} of the first set request at or above p, wrapping.
    function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [2:0] p);
        logic [3:0] res;
        int         c;
        res = 4'b0000;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = (int'(p) + k) % NUM_REQ;
            if (r[c]) begin
                res = {1'b1, c[2:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state and next-output logic for the grant/handshake/timeout sequence.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        ack_s      = '0;
        tx_send_s  = tx_send_r;
        tx_data_s  = tx_data_r;
        busy_s     = busy_r;
        err_s      = 1'b0;
        err_id_s   = err_id_r;
        ptr_s      = ptr_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        {found_s, win_s} = rr_pick(req, ptr_r);
        next_ptr_s = (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
        cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        win_oh_s   = '0;
        win_data_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == 3'(i)) begin
                win_oh_s[i] = 1'b1;
                win_data_s  = din[8*i +: 8];
            end else begin
                win_oh_s[i] = 1'b0;
            end
        end

        case (state_r)
            IDLE: begin
                // The ack/err term gives the dead cycle that ignores a stale req.
                if (found_s && !tx_done && (ack_r == '0) && !err_r) begin
                    state_s   = SEND;
                    gnt_s     = win_oh_s;
                    idx_s     = win_s;
                    tx_data_s = win_data_s;
                    tx_send_s = 1'b1;
                    busy_s    = 1'b1;
                    cnt_s     = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                cnt_s = cnt_inc_s;
                if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    err_s     = 1'b1;
                    err_id_s  = idx_r;
                    gnt_s     = '0;
                    tx_send_s = 1'b0;
                    busy_s    = 1'b0;
                    ptr_s     = next_ptr_s;
                end else if (tx_done) begin
                    state_s   = RELEASE;
                    tx_send_s = 1'b0;
                end else begin
                    state_s = SEND;
                end
            end
            RELEASE: begin
                cnt_s = cnt_inc_s;
                if (!tx_done) begin
                    state_s = IDLE;
                    ack_s   = gnt_r;
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    ptr_s   = next_ptr_s;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = IDLE;
                    err_s    = 1'b1;
                    err_id_s = idx_r;
                    gnt_s    = '0;
                    busy_s   = 1'b0;
                    ptr_s    = next_ptr_s;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s   = IDLE;
                gnt_s     = '0;
                tx_send_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            ack_r     <= '0;
            tx_send_r <= 1'b0;
            tx_data_r <= 8'h00;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            err_id_r  <= 3'd0;
            ptr_r     <= 3'd0;
            idx_r     <= 3'd0;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            ack_r     <= ack_s;
            tx_send_r <= tx_send_s;
            tx_data_r <= tx_data_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
            err_id_r  <= err_id_s;
            ptr_r     <= ptr_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
        end
    end

    assign gnt     = gnt_r;
    assign ack     = ack_r;
    assign tx_send = tx_send_r;
    assign tx_data = tx_data_r;
    assign busy    = busy_r;
    assign err     = err_r;
    assign err_id  = err_id_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transmitter model, a round-robin order model
// and a monitor that checks every grant and every ack/err against queued expectations.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int T = 64;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         is_err;
        int         lat;
    } exp_t;

    typedef struct {
        int d;
        int h;
        bit stuck;
    } beh_t;

    logic           clk, rst;
    logic [N-1:0]   req, gnt, ack;
    logic [8*N-1:0] din;
    logic           tx_send, tx_done, busy, err;
    logic [7:0]     tx_data;
    logic [2:0]     err_id;
    logic           model_done, force_done;
    bit             tx_active;
    bit             drop_all;

    exp_t       exp_q[$];
    beh_t       beh_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         ptr_m = 0;
    int         d_a[N];
    int         h_a[N];
    bit         s_a[N];
    logic [7:0] b_a[N];

    assign tx_done = model_done | force_done;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .ack(ack),
        .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
        .err(err), .err_id(err_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Queue one transaction: transmitter behaviour plus the outcome the rules predict.
    task automatic push_txn(input int id, input logic [7:0] data, input int d, input int h, input bit stuck);
        exp_t e;
        beh_t b;
        b.d = d; b.h = h; b.stuck = stuck;
        beh_q.push_back(b);
        e.id = id; e.data = data;
        if (!stuck && (d + h <= T - 1)) begin
            e.is_err = 1'b0; e.lat = d + h + 1;
        end else begin
            e.is_err = 1'b1; e.lat = T;
        end
        exp_q.push_back(e);
    endtask

    // Transmitter model: done rises d cycles after send is seen, falls h cycles later.
    initial begin
        int   t;
        beh_t b;
        model_done = 1'b0;
        tx_active  = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_active  = 1'b0;
                model_done = 1'b0;
            end else if (!tx_active) begin
                if (tx_send && beh_q.size() > 0) begin
                    b = beh_q.pop_front();
                    tx_active = 1'b1;
                    t = 0;
                end
            end else begin
                t++;
                if (b.stuck) begin
                    if (!tx_send) tx_active = 1'b0;
                end else begin
                    if (t == b.d) model_done = 1'b1;
                    if (t == b.d + b.h) begin
                        model_done = 1'b0;
                        tx_active  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: checks each grant and each ack/err against the head of the scoreboard.
    initial begin
        int           cyc, g_cyc, cur_id;
        logic [7:0]   cur_data;
        logic [N-1:0] prev_gnt;
        exp_t         e;
        cyc = 0; g_cyc = 0; cur_id = 0; cur_data = 8'h00; prev_gnt = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_gnt = '0;
            end else begin
                if (gnt != '0 && prev_gnt == '0) begin
                    g_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", 32'(gnt), 32'd0);
                    end else begin
                        e = exp_q[0];
                        cur_id = e.id; cur_data = e.data;
                        check("grant_id", 32'(gnt), 32'd1 << e.id);
                        check("grant_data", 32'(tx_data), 32'(e.data));
                        check("grant_send", 32'(tx_send), 32'd1);
                        check("grant_busy", 32'(busy), 32'd1);
                    end
                end else if (gnt != '0) begin
                    check("held_gnt", 32'(gnt), 32'd1 << cur_id);
                    check("held_data", 32'(tx_data), 32'(cur_data));
                end
                if (ack != '0 || err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack_err", {27'd0, err, ack}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("err_flag", 32'(err), 32'(e.is_err));
                        check("ack_vec", 32'(ack), e.is_err ? 32'd0 : (32'd1 << e.id));
                        if (e.is_err) check("err_id", 32'(err_id), 32'(e.id));
                        check("latency", 32'(cyc - g_cyc), 32'(e.lat));
                        check("end_send", 32'(tx_send), 32'd0);
                        check("end_gnt", 32'(gnt), 32'd0);
                        check("end_busy", 32'(busy), 32'd0);
                    end
                end
                prev_gnt = gnt;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        exp_q.delete();
        beh_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        @(negedge clk);
    endtask

    // Requester behaviour: drop req after ack/err, scramble din once granted.
    task automatic drive(input bit reraise0, input logic [7:0] byte2);
        logic [N-1:0] prev_g;
        bit           pend, done_rr;
        int           c;
        prev_g = '0; pend = 1'b0; done_rr = 1'b0; c = 0;
        while (c < 3000 && !(req == '0 && exp_q.size() == 0 && !tx_active && !pend)) begin
            if (pend) begin
                req[0] = 1'b1;
                din[7:0] = byte2;
                pend = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && !prev_g[i]) begin
                    din[8*i +: 8] = 8'($urandom);
                    if (drop_all || $urandom_range(0, 3) == 0) req[i] = 1'b0;
                end
                if (ack[i] || (err && int'(err_id) == i)) begin
                    req[i] = 1'b0;
                    if (reraise0 && i == 0 && !done_rr) begin
                        pend = 1'b1;
                        done_rr = 1'b1;
                    end
                end
            end
            prev_g = gnt;
            @(negedge clk);
            c++;
        end
        if (c >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL round_budget: %0d cycles elapsed, required completion within 3000", c);
            do_reset();
        end
    endtask

    // Expected order: requesters of mask ascending from the model pointer with wrap.
    task automatic run_round(input logic [N-1:0] mask, input bit reraise0);
        int         ord[$];
        int         id;
        logic [7:0] byte2;
        byte2 = 8'($urandom);
        for (int i = 0; i < N; i++) din[8*i +: 8] = b_a[i];
        for (int k = 0; k < N; k++) begin
            id = (ptr_m + k) % N;
            if (mask[id]) ord.push_back(id);
        end
        if (reraise0) ord.push_back(0);
        for (int j = 0; j < ord.size(); j++) begin
            push_txn(ord[j], (reraise0 && j == ord.size() - 1) ? byte2 : b_a[ord[j]],
                     d_a[ord[j]], h_a[ord[j]], s_a[ord[j]]);
        end
        ptr_m = (ord[ord.size() - 1] + 1) % N;
        req = mask;
        @(negedge clk);
        check("grant_latency", 32'(gnt), 32'd1 << ord[0]);
        drive(reraise0, byte2);
        repeat (2) @(negedge clk);
    endtask

    task automatic set_all(input int d, input int h);
        for (int i = 0; i < N; i++) begin
            d_a[i] = d; h_a[i] = h; s_a[i] = 1'b0; b_a[i] = 8'($urandom);
        end
    endtask

    initial begin
        logic [N-1:0] seen_g;
        logic [1:0]   seen_e;
        int           c;
        rst = 1'b1; req = '0; din = '0; force_done = 1'b0; drop_all = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_send", 32'(tx_send), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_id", 32'(err_id), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fairness: all four, requester 0 re-raised after its ack goes after 3.
        set_all(5, 3);
        run_round(4'b1111, 1'b1);

        // Single request with a fixed byte.
        set_all(20, 10);
        b_a[2] = 8'hA5;
        run_round(4'b0100, 1'b0);

        // Timeout with done stuck low, then a normal grant.
        set_all(10, 5);
        s_a[1] = 1'b1;
        run_round(4'b0010, 1'b0);
        s_a[1] = 1'b0;
        run_round(4'b0100, 1'b0);

        // Completion on the last counter value wins; one cycle later it times out.
        set_all(20, T - 21);
        run_round(4'b0001, 1'b0);
        set_all(20, T - 20);
        run_round(4'b0001, 1'b0);

        // Requester drops req during SEND; the latched byte is still sent.
        set_all(15, 4);
        drop_all = 1'b1;
        run_round(4'b0001, 1'b0);
        drop_all = 1'b0;

        // Stale done level blocks the grant until it falls.
        force_done = 1'b1;
        din[7:0] = 8'h5A;
        push_txn(0, 8'h5A, 6, 3, 1'b0);
        req = 4'b0001;
        seen_g = '0;
        repeat (6) begin
            @(negedge clk);
            seen_g |= gnt;
        end
        check("stale_done_no_grant", 32'(seen_g), 32'd0);
        force_done = 1'b0;
        @(negedge clk);
        check("stale_done_grant", 32'(gnt), 32'd1);
        ptr_m = 1;
        drive(1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // Reset in the middle of SEND.
        din[15:8] = 8'h3C;
        push_txn(1, 8'h3C, 30, 5, 1'b0);
        req = 4'b0010;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!gnt[1] && c < 10);
        check("rst_mid_grant", 32'(gnt), 32'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        beh_q.delete();
        @(negedge clk);
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_send", 32'(tx_send), 32'd0);
        check("rst_mid_data", 32'(tx_data), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ack_err", {27'd0, err, ack}, 32'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        seen_e = 2'b00;
        repeat (80) begin
            @(negedge clk);
            seen_e |= {(ack != '0), err};
        end
        check("no_evt_after_rst", 32'(seen_e), 32'd0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                d_a[i] = $urandom_range(1, T - 3);
                h_a[i] = $urandom_range(1, 50);
                s_a[i] = ($urandom_range(0, 7) == 0);
                b_a[i] = 8'($urandom);
            end
            run_round(4'($urandom_range(1, 15)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end
endmodule
